stream_demux_1xn: RTL
=====================

STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter N, default 4, number of output channels (2..16).
REQ-003 SHALL have localparam SW = clog2(N), the select width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_data  input  DW  input payload.
REQ-007 SHALL have port i_valid  input  1  input beat present.
REQ-008 SHALL have port i_ready  output  1  input beat accepted this cycle when i_valid also high.
REQ-009 SHALL have port s  input  SW  destination channel, sampled with each beat.
REQ-010 SHALL have port i_last  input  1  final beat of a packet; ignored unless the packet-lock feature is compiled in.
REQ-011 SHALL have port y_data  output  N*DW  channel k occupies bits [k*DW +: DW].
REQ-012 SHALL have port y_valid  output  N  per-channel beat present.
REQ-013 SHALL have port y_ready  input  N  per-channel downstream accept.
REQ-014 SHALL have port drop  output  1  one-cycle pulse, beat discarded for an out-of-range select.

Function
REQ-015 SHALL hold a one-entry output register per channel; y_data and y_valid are driven only from registers.
REQ-016 SHALL raise i_ready = !y_valid[d] || y_ready[d], where d is the effective destination; i_ready is combinational, with no dependency on i_valid.
REQ-017 SHALL, on accept (i_valid && i_ready), load channel d and set y_valid[d] on the next edge; latency is 1 cycle.
REQ-018 SHALL clear y_valid[k] after the edge where y_valid[k] && y_ready[k] and channel k is not reloaded that edge.
REQ-019 SHALL give a simultaneous drain and reload of the same channel full throughput: y_valid stays 1 and the new data appears.
REQ-020 SHALL never disturb other channels on a load; channels drain independently and concurrently.
REQ-021 SHALL hold y_data[k] stable while y_valid[k] && !y_ready[k].
REQ-022 SHALL treat d >= N (non-power-of-2 N) as follows: i_ready=1, the beat is discarded, and drop pulses high on the next cycle.
REQ-023 SHALL hold i_ready low toward a full, stalled channel; the input stalls and no beat is lost or duplicated.

Reset
REQ-024 SHALL, on rst asserted at any time, including mid-packet, asynchronously clear y_valid to 0, y_data to 0 and drop to 0, and set lock state to IDLE.
REQ-025 SHALL resume accepting on the first clk edge after rst deasserts; partially delivered packets are not replayed.

Configuration
REQ-026 SHALL provide the macro STREAM_DEMUX_PKT_LOCK_EN.
REQ-027 SHALL, when STREAM_DEMUX_PKT_LOCK_EN is defined, implement FSM IDLE/LOCKED: IDLE->LOCKED on accept with i_last=0, latching s as d.
REQ-028 SHALL, when STREAM_DEMUX_PKT_LOCK_EN is defined, ignore s while LOCKED, use the latched d, and go LOCKED->IDLE on accept with i_last=1.
REQ-029 SHALL, when STREAM_DEMUX_PKT_LOCK_EN is defined, treat a single-beat packet (i_last=1 in IDLE) as staying in IDLE.
REQ-030 SHALL drop a whole packet whose first-beat select is out of range, pulsing drop on every discarded beat.
REQ-031 SHALL, when STREAM_DEMUX_PKT_LOCK_EN is undefined, use d = s on every beat; i_last SHALL have no effect, and no FSM SHALL be present.

Structure
REQ-032 SHALL place the default DW/N values and the lock-state enum (IDLE, LOCKED) in package stream_demux_pkg.
REQ-033 SHALL implement the per-channel output register as sub-module demux_chan_reg (data, valid, load, ready), instantiated N times via generate.

Verification
REQ-034 SHALL cover: DW=8, N=4, y_ready=all ones, beats 0xA1/s=2 then 0xB2/s=0 -> y_valid[2] with 0xA1 one cycle later, then y_valid[0] with 0xB2, and i_ready held 1.
REQ-035 SHALL cover: y_ready[1]=0, two beats to s=1 -> first beat held stable, i_ready=0 on the second; raising y_ready[1] delivers the second beat next cycle with nothing lost.
REQ-036 SHALL cover: channel 3 continuously fed with y_ready[3]=1 -> one beat per cycle, y_valid[3] never dropping (simultaneous drain and reload).
REQ-037 SHALL cover: N=3, s=3 with i_valid=1 -> i_ready=1, drop pulses one cycle, and all y_valid stay 0.
REQ-038 SHALL cover: with lock enabled, a 3-beat packet starting at s=1 while s toggles to 0 mid-packet -> all beats go to channel 1, and the FSM returns to IDLE after i_last.
REQ-039 SHALL cover: rst pulsed mid-packet with channels full -> all y_valid=0 immediately, FSM in IDLE, and the next beat routes per the current s.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared defaults and the packet-lock state type for the 1:N stream demultiplexer.
package stream_demux_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int N_DEFAULT  = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel (valid/ready skid-free slot).
module demux_chan_reg
  import stream_demux_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic          valid
);

  // A load wins over a drain, so a same-cycle drain and reload keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// 1:N stream demultiplexer with registered per-channel outputs.
// Optional packet lock (route a whole packet by its first-beat select) via STREAM_DEMUX_PKT_LOCK_EN.
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int N  = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        i_data,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [$clog2(N)-1:0] s,
  input  logic                 i_last,
  output logic [N*DW-1:0]      y_data,
  output logic [N-1:0]         y_valid,
  input  logic [N-1:0]         y_ready,
  output logic                 drop
);

  localparam int SW = $clog2(N);
  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  logic [SW-1:0] dest_s;
  logic          in_range_s;
  logic          full_s;
  logic          accept_s;
  logic [N-1:0]  load_s;
  logic          drop_r;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  lock_state_e   state_r;
  lock_state_e   state_nxt_s;
  logic [SW-1:0] lock_d_r;
  logic [SW-1:0] lock_d_nxt_s;

  // Lock state and latched destination registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      lock_d_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      lock_d_r <= lock_d_nxt_s;
    end
  end

  // While locked the live select is ignored in favour of the first beat's select.
  always_comb begin
    dest_s = s;
    if (state_r == LOCKED) begin
      dest_s = lock_d_r;
    end else begin
      dest_s = s;
    end
  end

  // Next-state: open a packet on a non-final accept, close it on the final one.
  always_comb begin
    state_nxt_s  = state_r;
    lock_d_nxt_s = lock_d_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !i_last) begin
          state_nxt_s  = LOCKED;
          lock_d_nxt_s = s;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && i_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end
`else
  logic unused_last_s;
  assign unused_last_s = i_last;

  // Without packet lock every beat is routed by its own select.
  always_comb begin
    dest_s = s;
  end
`endif

  // Out-of-range destinations never match a channel, so they always look ready.
  always_comb begin
    in_range_s = ({1'b0, dest_s} < N_EXT);
    full_s     = 1'b0;
    for (int k = 0; k < N; k++) begin
      full_s = full_s | ((dest_s == SW'(k)) && y_valid[k] && !y_ready[k]);
    end
  end

  assign i_ready  = !full_s;
  assign accept_s = i_valid && i_ready;

  // One-hot channel load strobe.
  always_comb begin
    load_s = '0;
    for (int k = 0; k < N; k++) begin
      load_s[k] = accept_s && (dest_s == SW'(k));
    end
  end

  // Discard pulse for beats accepted toward a non-existent channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= accept_s && !in_range_s;
    end
  end

  assign drop = drop_r;

  for (genvar g = 0; g < N; g++) begin : g_chan
    demux_chan_reg #(
      .DW(DW)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s[g]),
      .load_data (i_data),
      .ready     (y_ready[g]),
      .data      (y_data[g*DW +: DW]),
      .valid     (y_valid[g])
    );
  end

endmodule
